// File: rtl/game_pkg.sv
// Constants and types shared across the game datapath and the frame renderer.
package game_pkg;

  localparam logic [2:0] COL_SKY    = 3'b011;
  localparam logic [2:0] COL_PIPE   = 3'b110;
  localparam logic [2:0] COL_BIRD   = 3'b100;
  localparam logic [2:0] COL_GROUND = 3'b010;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } render_state_t;

endpackage

// File: rtl/frame_renderer_if.sv
// Frame request, scene inputs and the pixel stream towards vga_adapter.
interface frame_renderer_if #(
  parameter int unsigned NUM_PIPES = 4
);

  logic                     frame_req;
  logic [6:0]               bird_y;
  logic [NUM_PIPES*8-1:0]   pipe_x;
  logic [NUM_PIPES*7-1:0]   pipe_gap;
  logic                     busy;
  logic                     done;
  logic [7:0]               x;
  logic [6:0]               y;
  logic [2:0]               colour;
  logic                     plot;
  logic                     collide;

  modport master (
    output frame_req, bird_y, pipe_x, pipe_gap,
    input  busy, done, x, y, colour, plot, collide
  );

  modport slave (
    input  frame_req, bird_y, pipe_x, pipe_gap,
    output busy, done, x, y, colour, plot, collide
  );

endinterface

// File: rtl/frame_renderer_pixel_classifier.sv
// Stateless pixel classifier: maps (x, y) and the scene snapshot to a colour
// plus the bird/pipe/ground membership flags.
module pixel_classifier
  import game_pkg::*;
#(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned PIPE_W    = 4,
  parameter int unsigned GAP_H     = 24,
  parameter int unsigned BIRD_X    = 20,
  parameter int unsigned BIRD_W    = 4,
  parameter int unsigned BIRD_H    = 4,
  parameter int unsigned GROUND_Y  = 110
) (
  input  logic [7:0]             x_i,
  input  logic [6:0]             y_i,
  input  logic [6:0]             bird_y_i,
  input  logic [NUM_PIPES*8-1:0] pipe_x_i,
  input  logic [NUM_PIPES*7-1:0] pipe_gap_i,
  output logic [2:0]             colour_o,
  output logic                   is_bird_o,
  output logic                   is_pipe_o,
  output logic                   is_ground_o
);

  // All bounds are 9 bits wide so right/bottom edges clip instead of wrapping.
  logic [8:0] x9, y9, by9, px9, gap9;

  assign x9  = {1'b0, x_i};
  assign y9  = {2'b0, y_i};
  assign by9 = {2'b0, bird_y_i};

  always_comb begin
    px9  = '0;
    gap9 = '0;
    is_bird_o = (x9 >= 9'(BIRD_X)) && (x9 < 9'(BIRD_X + BIRD_W)) &&
                (y9 >= by9) && (y9 < by9 + 9'(BIRD_H));
    is_pipe_o = 1'b0;
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      px9  = {1'b0, pipe_x_i[8*i +: 8]};
      gap9 = {2'b0, pipe_gap_i[7*i +: 7]};
      if ((gap9 != '0) && (x9 >= px9) && (x9 < px9 + 9'(PIPE_W)) &&
          ((y9 < gap9) || (y9 >= gap9 + 9'(GAP_H))))
        is_pipe_o = 1'b1;
    end
    is_ground_o = (y9 >= 9'(GROUND_Y));

    if (is_bird_o)        colour_o = COL_BIRD;
    else if (is_pipe_o)   colour_o = COL_PIPE;
    else if (is_ground_o) colour_o = COL_GROUND;
    else                  colour_o = COL_SKY;
  end

endmodule

// File: rtl/frame_renderer.sv
// Row-major pixel scan of one 160x120 frame per accepted request, one pixel per clock.
// FRAME_RENDERER_COLLIDE_EN builds the sticky bird collision flag; otherwise collide is 0.
module frame_renderer
  import game_pkg::*;
#(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned PIPE_W    = 4,
  parameter int unsigned GAP_H     = 24,
  parameter int unsigned BIRD_X    = 20,
  parameter int unsigned BIRD_W    = 4,
  parameter int unsigned BIRD_H    = 4,
  parameter int unsigned GROUND_Y  = 110
) (
  input  logic             clk,
  input  logic             resetn,
  frame_renderer_if.slave  bus
);

  render_state_t          state_q, state_d;
  logic [7:0]             x_cnt_q, x_cnt_d;
  logic [6:0]             y_cnt_q, y_cnt_d;
  logic [6:0]             bird_y_q, bird_y_d;
  logic [NUM_PIPES*8-1:0] pipe_x_q, pipe_x_d;
  logic [NUM_PIPES*7-1:0] pipe_gap_q, pipe_gap_d;
  logic [7:0]             x_q, x_d;
  logic [6:0]             y_q, y_d;
  logic [2:0]             colour_q, colour_d;
  logic                   plot_q, plot_d;
  logic                   done_q, done_d;

  logic [2:0] pix_colour;
  logic       is_bird, is_pipe, is_ground;
  logic       accept, scanning, last_px;

  pixel_classifier #(
    .NUM_PIPES (NUM_PIPES),
    .PIPE_W    (PIPE_W),
    .GAP_H     (GAP_H),
    .BIRD_X    (BIRD_X),
    .BIRD_W    (BIRD_W),
    .BIRD_H    (BIRD_H),
    .GROUND_Y  (GROUND_Y)
  ) u_classifier (
    .x_i         (x_cnt_q),
    .y_i         (y_cnt_q),
    .bird_y_i    (bird_y_q),
    .pipe_x_i    (pipe_x_q),
    .pipe_gap_i  (pipe_gap_q),
    .colour_o    (pix_colour),
    .is_bird_o   (is_bird),
    .is_pipe_o   (is_pipe),
    .is_ground_o (is_ground)
  );

  assign accept   = (state_q == ST_IDLE) && bus.frame_req;
  assign scanning = (state_q == ST_SCAN);
  assign last_px  = (x_cnt_q == 8'(SCREEN_W - 1)) && (y_cnt_q == 7'(SCREEN_H - 1));

  always_comb begin
    state_d    = state_q;
    x_cnt_d    = x_cnt_q;
    y_cnt_d    = y_cnt_q;
    bird_y_d   = bird_y_q;
    pipe_x_d   = pipe_x_q;
    pipe_gap_d = pipe_gap_q;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.frame_req) begin
          state_d    = ST_SCAN;
          x_cnt_d    = '0;
          y_cnt_d    = '0;
          bird_y_d   = bus.bird_y;
          pipe_x_d   = bus.pipe_x;
          pipe_gap_d = bus.pipe_gap;
        end
      end
      ST_SCAN: begin
        x_d      = x_cnt_q;
        y_d      = y_cnt_q;
        colour_d = pix_colour;
        plot_d   = 1'b1;
        if (last_px) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (x_cnt_q == 8'(SCREEN_W - 1)) begin
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + 7'd1;
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      bird_y_q   <= '0;
      pipe_x_q   <= '0;
      pipe_gap_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      bird_y_q   <= bird_y_d;
      pipe_x_q   <= pipe_x_d;
      pipe_gap_q <= pipe_gap_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      done_q     <= done_d;
    end
  end

`ifdef FRAME_RENDERER_COLLIDE_EN
  logic collide_q, collide_d;

  // Sticky across the scan; includes the last pixel, so it is complete when done pulses.
  always_comb begin
    collide_d = collide_q;
    if (accept)
      collide_d = 1'b0;
    else if (scanning && is_bird && (is_pipe || is_ground))
      collide_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) collide_q <= 1'b0;
    else         collide_q <= collide_d;
  end

  assign bus.collide = collide_q;
`else
  logic unused_class;
  assign unused_class = is_bird ^ is_pipe ^ is_ground ^ accept;
  assign bus.collide  = 1'b0;
`endif

  assign bus.busy   = scanning;
  assign bus.done   = done_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Self-checking bench for frame_renderer: whole frames captured and compared
// against a per-pixel scene model, plus fixed probe points and timing checks.
module tb_frame_renderer;
  import game_pkg::*;

  localparam int NP       = 4;
  localparam int NPIX     = 160 * 120;
  localparam int M_PIPE_W = 4;
  localparam int M_GAP_H  = 24;
  localparam int M_BIRD_X = 20;
  localparam int M_BIRD_W = 4;
  localparam int M_BIRD_H = 4;
  localparam int M_GROUND = 110;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  frame_renderer_if #(.NUM_PIPES(NP)) bus ();

  frame_renderer #(
    .NUM_PIPES (NP),
    .PIPE_W    (M_PIPE_W),
    .GAP_H     (M_GAP_H),
    .BIRD_X    (M_BIRD_X),
    .BIRD_W    (M_BIRD_W),
    .BIRD_H    (M_BIRD_H),
    .GROUND_Y  (M_GROUND)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scene model and captured frame
  int m_bird;
  int m_px  [NP];
  int m_gap [NP];
  int got_col [NPIX];
  int done_k, plot_cnt, order_err, first_plot_k, busy_at_done, coll_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_is_bird(int x, int y);
    return (x >= M_BIRD_X) && (x < M_BIRD_X + M_BIRD_W) &&
           (y >= m_bird) && (y < m_bird + M_BIRD_H);
  endfunction

  function automatic bit m_is_pipe(int x, int y);
    for (int i = 0; i < NP; i++)
      if (m_gap[i] != 0 && x >= m_px[i] && x < m_px[i] + M_PIPE_W &&
          (y < m_gap[i] || y >= m_gap[i] + M_GAP_H))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_colour(int x, int y);
    if (m_is_bird(x, y)) return 4;
    if (m_is_pipe(x, y)) return 6;
    if (y >= M_GROUND)   return 2;
    return 3;
  endfunction

  function automatic int m_collide();
`ifdef FRAME_RENDERER_COLLIDE_EN
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        if (m_is_bird(x, y) && (m_is_pipe(x, y) || y >= M_GROUND)) return 1;
`endif
    return 0;
  endfunction

  function automatic int pix(int x, int y);
    return got_col[y * 160 + x];
  endfunction

  task automatic drive_scene();
    bus.bird_y = 7'(m_bird);
    for (int i = 0; i < NP; i++) begin
      bus.pipe_x[8*i +: 8]   = 8'(m_px[i]);
      bus.pipe_gap[7*i +: 7] = 7'(m_gap[i]);
    end
  endtask

  // Called at a negedge; mode 1 = extra request at pixel 3000, mode 2 = reset at pixel 5000.
  task automatic run_frame(input int mode);
    int p;
    bit seen_done;
    done_k = -1; plot_cnt = 0; order_err = 0; first_plot_k = -1;
    busy_at_done = -1; coll_done = -1;
    for (int i = 0; i < NPIX; i++) got_col[i] = -1;
    drive_scene();
    bus.frame_req = 1'b1;
    @(negedge clk);
    bus.frame_req = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 1);
    check("done_low_at_accept", 32'(bus.done), 0);
    check("plot_low_at_accept", 32'(bus.plot), 0);
    seen_done = 1'b0;
    for (int k = 1; k <= NPIX + 20 && !seen_done; k++) begin
      @(negedge clk);
      if (bus.plot) begin
        p = int'(bus.y) * 160 + int'(bus.x);
        if (first_plot_k < 0) first_plot_k = k;
        if (bus.x > 8'd159 || p >= NPIX || p != plot_cnt) order_err++;
        else got_col[p] = int'(bus.colour);
        plot_cnt++;
      end
      if (bus.done) begin
        done_k = k; busy_at_done = int'(bus.busy); coll_done = int'(bus.collide);
        seen_done = 1'b1;
      end
      if (mode == 1 && k == 3000) begin bus.frame_req = 1'b1; bus.bird_y = 7'd10; end
      if (mode == 1 && k == 3001) bus.frame_req = 1'b0;
      if (mode == 2 && k == 5000) begin
        resetn = 1'b0;
        #1;
        check("rst_plot", 32'(bus.plot), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_collide", 32'(bus.collide), 0);
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
    end
    check("done_cycle", done_k, NPIX);
    check("plot_count", plot_cnt, NPIX);
    check("scan_order", order_err, 0);
    check("first_pixel_cycle", first_plot_k, 1);
    check("busy_at_done", busy_at_done, 0);
    check("collide_at_done", coll_done, m_collide());
    begin
      int bad, first_bad;
      bad = 0; first_bad = -1;
      for (int i = 0; i < NPIX; i++)
        if (got_col[i] != m_colour(i % 160, i / 160)) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      if (bad != 0) $display("first bad pixel x=%0d y=%0d", first_bad % 160, first_bad / 160);
      check("frame_pixels", bad, 0);
    end
  endtask

  initial begin
    bus.frame_req = 1'b0;
    bus.bird_y    = '0;
    bus.pipe_x    = '0;
    bus.pipe_gap  = '0;
    repeat (3) @(negedge clk);
    check("reset_x", 32'(bus.x), 0);
    check("reset_y", 32'(bus.y), 0);
    check("reset_colour", 32'(bus.colour), 0);
    check("reset_plot", 32'(bus.plot), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_collide", 32'(bus.collide), 0);
    resetn = 1'b1;
    @(negedge clk);

    // Frame 1: empty sky, bird at 50, ignored mid-frame request
    m_bird = 50;
    for (int i = 0; i < NP; i++) begin m_px[i] = 0; m_gap[i] = 0; end
    run_frame(1);
    check("f1_0_0", pix(0, 0), 3);
    check("f1_20_50", pix(20, 50), 4);
    check("f1_23_53", pix(23, 53), 4);
    check("f1_24_50", pix(24, 50), 3);
    check("f1_5_115", pix(5, 115), 2);
    check("f1_collide", coll_done, 0);

    // Frame 2 back-to-back: bird now at 10, pipe at 30 and clipped pipe at 158
    m_bird = 10;
    m_px[0] = 30;  m_gap[0] = 40;
    m_px[1] = 158; m_gap[1] = 40;
    run_frame(0);
    check("f2_bird_20_10", pix(20, 10), 4);
    check("f2_old_bird_20_50", pix(20, 50), 3);
    check("f2_30_10", pix(30, 10), 6);
    check("f2_33_70", pix(33, 70), 6);
    check("f2_30_40", pix(30, 40), 3);
    check("f2_33_63", pix(33, 63), 3);
    check("f2_34_10", pix(34, 10), 3);
    check("f2_30_112", pix(30, 112), 6);
    check("f2_158_10", pix(158, 10), 6);
    check("f2_159_10", pix(159, 10), 6);
    check("f2_157_10", pix(157, 10), 3);
    check("f2_0_10", pix(0, 10), 3);
    check("f2_1_10", pix(1, 10), 3);

    // Frame 3: aborted by reset after pixel 5000
    m_bird = 10;
    m_px[0] = 20; m_gap[0] = 60;
    m_gap[1] = 0;
    run_frame(2);

    // Frame 4: bird inside pipe column, random extra pipes
    @(negedge clk);
    m_bird = 50;
    m_px[0] = 20; m_gap[0] = 60;
    for (int i = 1; i < NP; i++) begin
      m_px[i]  = int'($urandom_range(0, 255));
      m_gap[i] = int'($urandom_range(0, 127));
    end
    run_frame(0);
    check("f4_bird_over_pipe", pix(21, 51), 4);
    check("f4_pipe_20_10", pix(20, 10) == 4 ? 6 : pix(20, 10), 6);
`ifdef FRAME_RENDERER_COLLIDE_EN
    check("f4_collide", coll_done, 1);
`else
    check("f4_collide", coll_done, 0);
`endif

    // Frame 5: fully random scene, bird near/over the bottom edge
    m_bird = int'($urandom_range(100, 127));
    for (int i = 0; i < NP; i++) begin
      m_px[i]  = int'($urandom_range(0, 255));
      m_gap[i] = int'($urandom_range(0, 127));
    end
    run_frame(0);

    @(negedge clk);
    check("idle_after_frames", 32'(bus.busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
